// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch BCD counter.
//   state_t  : run-control states (IDLE, RUN, PAUSE)
//   bcd_t    : one BCD digit
//   calc_div : prescaler divisor from clock and tick rates; returns 0 when
//              the ratio is not an exact integer >= 2 so the top can refuse
//              to elaborate.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam bcd_t L_MAX_UNIT = 4'd9;
   localparam bcd_t L_MAX_TENS = 4'd5;

   function automatic int calc_div(input longint freq, input longint hz);
      if (hz <= 0 || freq <= 0)  return 0;
      if ((freq % hz) != 0)      return 0;
      if ((freq / hz) < 2)       return 0;
      return int'(freq / hz);
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit counting 0..P_MAX.
//   CLK     : clock
//   RST     : synchronous active-high reset to 0
//   I_CLR   : synchronous clear to 0
//   I_INC   : advance by one (wraps P_MAX -> 0)
//   O_VAL   : current digit value
//   O_CARRY : combinational, high when this increment wraps the digit
module bcd_digit
   import stopwatch_pkg::*;
#(
   parameter bcd_t P_MAX = L_MAX_UNIT
) (
   input  logic CLK,
   input  logic RST,
   input  logic I_CLR,
   input  logic I_INC,
   output bcd_t O_VAL,
   output logic O_CARRY
);

   bcd_t val;

   always_ff @(posedge CLK) begin
      if (RST || I_CLR) begin
         val <= '0;
      end else if (I_INC) begin
         val <= (val == P_MAX) ? '0 : val + 4'd1;
      end
   end

   assign O_VAL   = val;
   assign O_CARRY = I_INC && (val == P_MAX);

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch timing stage: prescales CLK to a centisecond tick and accumulates
// elapsed time as six BCD digits MM:SS.cc under start/stop/clear control.
//   CLK          : clock
//   RST          : synchronous active-high reset
//   I_START_STOP : one-cycle pulse, toggles run/pause (starts from idle)
//   I_CLEAR      : one-cycle pulse, back to zero/idle; beats I_START_STOP
//   O_BCD        : {m1, m0, s1, s0, c1, c0}
//   O_RUNNING    : high while in RUN
//   O_TICK       : one-cycle pulse per prescaler terminal count
//   O_WRAP       : one-cycle pulse when 59:59.99 rolls to 00:00.00
//
// state | meaning
// IDLE  | cleared, prescaler at 0, waiting for start
// RUN   | prescaler counting, digits advance on each tick
// PAUSE | prescaler and digits frozen, fractional tick kept
module stopwatch_bcd_counter
   import stopwatch_pkg::*;
#(
   parameter int P_CLK_FREQ = 50_000_000,
   parameter int P_TICK_HZ  = 100
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        I_START_STOP,
   input  logic        I_CLEAR,
   output logic [23:0] O_BCD,
   output logic        O_RUNNING,
   output logic        O_TICK,
   output logic        O_WRAP
);

   localparam int L_DIV = calc_div(P_CLK_FREQ, P_TICK_HZ);
   localparam int L_PW  = (L_DIV >= 2) ? $clog2(L_DIV) : 1;
   localparam logic [L_PW-1:0] L_TC = L_PW'(L_DIV - 1);

   generate
      if (L_DIV < 2) begin : g_bad_div
         $fatal(1, "stopwatch_bcd_counter: P_CLK_FREQ/P_TICK_HZ must be an exact integer >= 2");
      end
   endgenerate

   state_t          state;
   logic [L_PW-1:0] presc;
   logic            tc;
   logic            inc;
   logic            carry_c0, carry_c1, carry_s0, carry_s1, carry_m0, carry_m1;
   bcd_t            c0, c1, s0, s1, m0, m1;

   // A start/stop pulse on the terminal count still lets the tick land;
   // only a clear suppresses it.
   assign tc  = (state == RUN) && (presc == L_TC);
   assign inc = tc && !I_CLEAR;

   always_ff @(posedge CLK) begin
      if (RST || I_CLEAR) begin
         state     <= IDLE;
         presc     <= '0;
         O_RUNNING <= 1'b0;
         O_TICK    <= 1'b0;
         O_WRAP    <= 1'b0;
      end else begin
         O_TICK <= inc;
         O_WRAP <= carry_m1;
         if (state == RUN) begin
            presc <= tc ? '0 : presc + L_PW'(1);
         end
         case (state)
            IDLE: begin
               if (I_START_STOP) begin
                  state     <= RUN;
                  O_RUNNING <= 1'b1;
               end
            end
            RUN: begin
               if (I_START_STOP) begin
                  state     <= PAUSE;
                  O_RUNNING <= 1'b0;
               end
            end
            PAUSE: begin
               if (I_START_STOP) begin
                  state     <= RUN;
                  O_RUNNING <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               O_RUNNING <= 1'b0;
            end
         endcase
      end
   end

   bcd_digit #(.P_MAX(L_MAX_UNIT)) u_c0 (
      .CLK(CLK), .RST(RST), .I_CLR(I_CLEAR), .I_INC(inc),
      .O_VAL(c0), .O_CARRY(carry_c0)
   );
   bcd_digit #(.P_MAX(L_MAX_UNIT)) u_c1 (
      .CLK(CLK), .RST(RST), .I_CLR(I_CLEAR), .I_INC(carry_c0),
      .O_VAL(c1), .O_CARRY(carry_c1)
   );
   bcd_digit #(.P_MAX(L_MAX_UNIT)) u_s0 (
      .CLK(CLK), .RST(RST), .I_CLR(I_CLEAR), .I_INC(carry_c1),
      .O_VAL(s0), .O_CARRY(carry_s0)
   );
   bcd_digit #(.P_MAX(L_MAX_TENS)) u_s1 (
      .CLK(CLK), .RST(RST), .I_CLR(I_CLEAR), .I_INC(carry_s0),
      .O_VAL(s1), .O_CARRY(carry_s1)
   );
   bcd_digit #(.P_MAX(L_MAX_UNIT)) u_m0 (
      .CLK(CLK), .RST(RST), .I_CLR(I_CLEAR), .I_INC(carry_s1),
      .O_VAL(m0), .O_CARRY(carry_m0)
   );
   // Carry out of the top digit only happens at 59:59.99, i.e. the wrap.
   bcd_digit #(.P_MAX(L_MAX_TENS)) u_m1 (
      .CLK(CLK), .RST(RST), .I_CLR(I_CLEAR), .I_INC(carry_m0),
      .O_VAL(m1), .O_CARRY(carry_m1)
   );

   assign O_BCD = {m1, m0, s1, s0, c1, c0};

endmodule

// File: doc/stopwatch_bcd_counter.md
Name: stopwatch_bcd_counter

Overview:
Upstream timing stage for the lesson-11 timer top level. Divides the 50 MHz board clock into a centisecond tick and accumulates elapsed time as six BCD digits (MM:SS.cc). A start/stop/clear FSM drives the counter. Its digit bus feeds the existing 7-segment/LED output stage directly; that stage only decodes and needs no timing logic of its own.

Parameters:
P_CLK_FREQ, 50_000_000, input clock frequency in Hz.
P_TICK_HZ, 100, tick rate in Hz. Prescaler divisor L_DIV = P_CLK_FREQ/P_TICK_HZ; must divide exactly and give L_DIV >= 2.

Ports:
CLK  input  1  single clock, 50 MHz on board.
RST  input  1  synchronous, active-high reset.
I_START_STOP  input  1  one-cycle pulse, already debounced; toggles run/pause.
I_CLEAR  input  1  one-cycle pulse; returns to zero/idle.
O_BCD  output  24  digits [3:0]=c0, [7:4]=c1, [11:8]=s0, [15:12]=s1, [19:16]=m0, [23:20]=m1.
O_RUNNING  output  1  high while in RUN.
O_TICK  output  1  one-cycle pulse per prescaler terminal count.
O_WRAP  output  1  one-cycle pulse when 59:59.99 rolls to 00:00.00.

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RST; all state changes only on posedge CLK.
- Reset values: O_BCD=0, O_RUNNING=0, O_TICK=0, O_WRAP=0, prescaler=0, state=IDLE. RST mid-count overrides every other input in the same cycle.
- FSM states are IDLE, RUN and PAUSE. Transitions:
  - IDLE + I_START_STOP -> RUN.
  - RUN + I_START_STOP -> PAUSE.
  - PAUSE + I_START_STOP -> RUN.
  - Any state + I_CLEAR -> IDLE, with digits=0 and prescaler=0.
- I_CLEAR has priority over I_START_STOP when both are high in the same cycle. That cycle ends in IDLE.
- O_RUNNING is registered and equals (state==RUN). It goes high on the edge that samples the start pulse.
- Prescaler:
  - Width is $clog2(L_DIV). It counts only in RUN.
  - In PAUSE it holds its value, so the fractional tick is preserved across pause/resume.
  - At L_DIV-1 in RUN it wraps to 0 on the next edge, and O_TICK is high for that one following cycle.
- Tick timing: the first O_TICK rises exactly L_DIV cycles after the edge that sampled I_START_STOP in IDLE.
- Digit update: digits update on the same edge O_TICK rises, so O_BCD and O_TICK change together.
- Digit rollover:
  - c0 0..9 carries into c1 0..9, which carries into s0 0..9.
  - s0 carries into s1 0..5, which carries into m0 0..9.
  - m0 carries into m1 0..5.
  - A carry occurs only when all lower digits are at max.
- Wrap: the tick at 59:59.99 gives 00:00.00 and O_WRAP=1 for one cycle, aligned with O_TICK. Counting continues in RUN.
- In IDLE and PAUSE no tick is generated, O_TICK=0, and digits hold.
- A start/stop pulse in the same cycle the prescaler hits L_DIV-1 in RUN: the tick still completes (digits increment, O_TICK pulses) and the state becomes PAUSE.
- A clear in the same cycle as a terminal count: clear wins, digits=0, no O_TICK, no O_WRAP.

Decomposition:
- Package stopwatch_pkg:
  - typedef enum logic [1:0] state_t {IDLE, RUN, PAUSE}.
  - typedef logic [3:0] bcd_t.
  - Constants L_MAX_UNIT=9 and L_MAX_TENS=5.
  - Function calc_div(freq, hz) with an elaboration-time check.
- Sub-module bcd_digit, instantiated 6 times:
  - Parameter P_MAX. Inputs CLK, RST, I_CLR, I_INC.
  - Outputs O_VAL (4 bits) and O_CARRY, combinational: I_INC && O_VAL==P_MAX.
- The top module holds the FSM, the prescaler, the carry chain and the wrap detect.

Test Plan:
- Reset and idle: hold RST 10 cycles, then idle 1000 cycles -> O_BCD=24'h0, O_RUNNING=0, no O_TICK.
- Tick period, with P_CLK_FREQ=1000 and P_TICK_HZ=100 (L_DIV=10): start pulse at cycle n -> O_TICK at n+10 and n+20; O_BCD=24'h000001, then 24'h000002.
- Full rate, default parameters: start, measure $time between consecutive O_TICK rises -> 10_000_000 ns. After 100 ticks O_BCD=24'h000100, i.e. 1 s = 10**9 ns from start.
- Pause/resume, L_DIV=10: start, pause after 15 cycles, wait 50, resume -> next tick 5 cycles after resume; O_BCD never changes while paused.
- Wrap, L_DIV=10: run to 59:59.99 (24'h595999) -> next tick gives 24'h000000 with O_WRAP=1 for exactly one cycle; O_RUNNING stays 1.
- Simultaneous I_CLEAR+I_START_STOP in RUN at the prescaler terminal count -> IDLE, O_BCD=0, O_TICK=0, O_WRAP=0, O_RUNNING=0 next cycle.
